// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder FSM state encodings and operation codes.
package alu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the bit slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, one bit per clock, LSB first. Subtract is A + ~B + 1,
// with the +1 supplied as the initial carry.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sr_shift;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign sr_shift = {fa_s, sr_q[WIDTH-1:1]};
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sr_d     = sr_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (state_q == S_RUN) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      sr_d    = sr_shift;
      carry_d = fa_c;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        state_d  = S_DONE;
        result_d = sr_shift;
        cout_d   = fa_c;
        // carry_q is the carry into the MSB on the final step
        ovf_d    = carry_q ^ fa_c;
        zero_d   = (sr_shift == '0);
      end
    end else if (accept) begin
      state_d = S_RUN;
      opa_d   = a;
      opb_d   = (mode == OP_SUB) ? ~b : b;
      carry_d = mode;
      cnt_d   = '0;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
